// File: rtl/apb_sd_spi_ctrl_if.sv
// APB3 bus bundle for the SD-card SPI controller.
interface apb_sd_spi_ctrl_if;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_sd_spi_ctrl.sv
// APB3 slave that sequences SD-card SPI pins (mode 0, MSB first): up to 32 bits per
// transfer, divided SCK, MISO shifted into a right-aligned receive word.
module apb_sd_spi_ctrl #(
  parameter int unsigned      DIV_W     = 8,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(62)
) (
  input  logic                clk,
  input  logic                reset,
  apb_sd_spi_ctrl_if.slave    apb,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                spi_cs_n,
  input  logic                spi_miso,
  output logic                irq_done
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned BI_W  = 5;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_q, div_nx, dc_q, dc_nx;
  logic               cs_q, cs_nx, irq_en_q, irq_en_nx;
  logic [31:0]        tx_q, tx_nx, rx_q, rx_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [BI_W-1:0]    bi_q, bi_nx;
  logic               done_q, done_nx, err_q, err_nx;
  logic               sck_q, sck_nx, mosi_q, mosi_nx;
  logic               cs_n_q, irq_q;

  logic               done_set, done_clr, err_set, err_clr;
  logic               wr, wr_ctrl, wr_tx, wr_cnt, wr_status;
  logic [2:0]         idx;
  logic [CNT_W-1:0]   cnt_n;
  logic               cnt_ok, busy;
  logic [BI_W-1:0]    start_bi, bi_dec;
  logic               unused_ok;

  assign idx       = apb.paddr[4:2];
  assign wr        = apb.psel & apb.penable & apb.pwrite;
  assign wr_ctrl   = wr && (idx == 3'd0);
  assign wr_tx     = wr && (idx == 3'd1);
  assign wr_cnt    = wr && (idx == 3'd2);
  assign wr_status = wr && (idx == 3'd3);
  assign cnt_n     = apb.pwdata[CNT_W-1:0];
  assign cnt_ok    = (cnt_n != '0) && (cnt_n <= CNT_W'(32));
  assign busy      = (state != IDLE);
  assign start_bi  = BI_W'(cnt_n - CNT_W'(1));
  assign bi_dec    = bi_q - BI_W'(1);
  assign unused_ok = &{1'b0, apb.paddr[7:5], apb.paddr[1:0]};

  // Register writes and the SCK/shift sequencer
  always_comb begin
    state_nx  = state;
    div_nx    = div_q;
    cs_nx     = cs_q;
    irq_en_nx = irq_en_q;
    tx_nx     = tx_q;
    rx_nx     = rx_q;
    cnt_nx    = cnt_q;
    dc_nx     = dc_q;
    bi_nx     = bi_q;
    sck_nx    = sck_q;
    mosi_nx   = mosi_q;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;

    // cs/irq_en always writable; an attempted divider change mid-transfer is an error
    if (wr_ctrl) begin
      cs_nx     = apb.pwdata[8];
      irq_en_nx = apb.pwdata[9];
      if (!busy)
        div_nx = apb.pwdata[DIV_W-1:0];
      else if (apb.pwdata[DIV_W-1:0] != div_q)
        err_set = 1'b1;
    end
    if (wr_tx) begin
      if (busy) err_set = 1'b1;
      else      tx_nx   = apb.pwdata;
    end
    if (wr_status) begin
      done_clr = apb.pwdata[1];
      err_clr  = apb.pwdata[2];
    end
    if (wr_cnt && (busy || !cnt_ok))
      err_set = 1'b1;

    case (state)
      IDLE: begin
        if (wr_cnt && cnt_ok) begin
          state_nx = LOW;
          cnt_nx   = cnt_n;
          bi_nx    = start_bi;
          mosi_nx  = tx_q[start_bi];
          rx_nx    = '0;
          dc_nx    = div_q;
        end
      end
      LOW: begin
        if (dc_q == '0) begin
          sck_nx   = 1'b1;
          rx_nx    = {rx_q[30:0], spi_miso};
          dc_nx    = div_q;
          state_nx = HIGH;
        end else begin
          dc_nx = dc_q - DIV_W'(1);
        end
      end
      HIGH: begin
        if (dc_q == '0) begin
          sck_nx = 1'b0;
          cnt_nx = cnt_q - CNT_W'(1);
          if (bi_q == '0) begin
            state_nx = IDLE;
            done_set = 1'b1;
            mosi_nx  = 1'b1;
          end else begin
            bi_nx    = bi_dec;
            mosi_nx  = tx_q[bi_dec];
            dc_nx    = div_q;
            state_nx = LOW;
          end
        end else begin
          dc_nx = dc_q - DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // A completion in the same cycle as a W1C keeps done set
    done_nx = (done_q & ~done_clr) | done_set;
    err_nx  = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= DIV_RESET;
      cs_q     <= 1'b0;
      irq_en_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      dc_q     <= '0;
      bi_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      div_q    <= div_nx;
      cs_q     <= cs_nx;
      irq_en_q <= irq_en_nx;
      tx_q     <= tx_nx;
      rx_q     <= rx_nx;
      cnt_q    <= cnt_nx;
      dc_q     <= dc_nx;
      bi_q     <= bi_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
      sck_q    <= sck_nx;
      mosi_q   <= mosi_nx;
      cs_n_q   <= ~cs_nx;
      irq_q    <= done_nx & irq_en_nx;
    end
  end

  // Read mux; unmapped addresses read all-ones
  always_comb begin
    apb.prdata = '1;
    case (idx)
      3'd0:    apb.prdata = {22'd0, irq_en_q, cs_q, 8'(div_q)};
      3'd1:    apb.prdata = tx_q;
      3'd2:    apb.prdata = {26'd0, cnt_q};
      3'd3:    apb.prdata = {29'd0, err_q, done_q, busy};
      3'd4:    apb.prdata = rx_q;
      default: apb.prdata = '1;
    endcase
  end

  assign apb.pready = 1'b1;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign irq_done   = irq_q;

endmodule
